// File: rtl/div_issue_ctrl.sv
// Operand sequencer for the 8-bit serial divider: buffers operand pairs in a FIFO,
// issues one start_sig operation per pair, traps divide-by-zero and times out hung ops.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid, once
// raised, holds its payload stable until that edge.
module div_issue_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_dividend,
  input  logic [7:0] in_divisor,
  output logic       div_start_sig,
  output logic [7:0] div_dividend,
  output logic [7:0] div_divisor,
  input  logic       div_done_sig,
  input  logic [7:0] div_quotient,
  input  logic [7:0] div_reminder,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_quotient,
  output logic [7:0] out_reminder,
  output logic       out_dz,
  output logic       out_timeout,
  output logic       busy,
  output logic [1:0] fsm_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [7:0]    mem_dividend [FIFO_DEPTH];
  logic [7:0]    mem_divisor  [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic [7:0]    head_dividend;
  logic [7:0]    head_divisor;
  logic [1:0]    state;
  logic [CW-1:0] cnt;

  // The extra pointer MSB separates the full and empty cases when the indices match.
  assign full          = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty         = (wr_ptr == rd_ptr);
  assign in_ready      = !full;
  assign push          = in_valid && in_ready;
  assign head_dividend = mem_dividend[rd_ptr[AW-1:0]];
  assign head_divisor  = mem_divisor[rd_ptr[AW-1:0]];
  assign busy          = (state != ST_IDLE) || !empty;
  assign fsm_state     = state;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_dividend[wr_ptr[AW-1:0]] <= in_dividend;
      mem_divisor[wr_ptr[AW-1:0]]  <= in_divisor;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      state         <= ST_IDLE;
      cnt           <= '0;
      div_start_sig <= 1'b0;
      div_dividend  <= 8'h00;
      div_divisor   <= 8'h00;
      out_valid     <= 1'b0;
      out_quotient  <= 8'h00;
      out_reminder  <= 8'h00;
      out_dz        <= 1'b0;
      out_timeout   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            rd_ptr       <= rd_ptr + 1'b1;
            div_dividend <= head_dividend;
            div_divisor  <= head_divisor;
            if (head_divisor == 8'h00) begin
              out_quotient <= 8'hFF;
              out_reminder <= head_dividend;
              out_dz       <= 1'b1;
              out_timeout  <= 1'b0;
              out_valid    <= 1'b1;
              state        <= ST_RESP;
            end else begin
              div_start_sig <= 1'b1;
              cnt           <= '0;
              state         <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          // Dropping start on the done edge returns the divider to step 0 without relaunch.
          if (div_done_sig) begin
            out_quotient  <= div_quotient;
            out_reminder  <= div_reminder;
            out_dz        <= 1'b0;
            out_timeout   <= 1'b0;
            out_valid     <= 1'b1;
            div_start_sig <= 1'b0;
            state         <= ST_RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            out_quotient  <= 8'h00;
            out_reminder  <= 8'h00;
            out_dz        <= 1'b0;
            out_timeout   <= 1'b1;
            out_valid     <= 1'b1;
            div_start_sig <= 1'b0;
            state         <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl with a behavioural 11-edge serial divider model attached.
module tb_div_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_dividend = 8'h00;
  logic [7:0] in_divisor = 8'h00;
  logic       div_start_sig;
  logic [7:0] div_dividend;
  logic [7:0] div_divisor;
  logic       div_done_sig;
  logic [7:0] div_quotient;
  logic [7:0] div_reminder;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_quotient;
  logic [7:0] out_reminder;
  logic       out_dz;
  logic       out_timeout;
  logic       busy;
  logic [1:0] fsm_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [17:0] exp_q[$];
  int hs_cyc[$];
  int cyc = 0;
  int start_cycles = 0;
  int done_pulses = 0;
  logic stuck = 1'b0;

  always #5 clk = ~clk;

  div_issue_ctrl #(.FIFO_DEPTH(4), .TIMEOUT(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor),
    .div_start_sig(div_start_sig), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done_sig(div_done_sig), .div_quotient(div_quotient), .div_reminder(div_reminder),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_reminder(out_reminder),
    .out_dz(out_dz), .out_timeout(out_timeout), .busy(busy), .fsm_state(fsm_state)
  );

  // Divider model: counts edges while start is high, done pulses on the 10th.
  logic [7:0] m_step;
  logic       m_done;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_step <= 8'h00;
      m_done <= 1'b0;
    end else if (!div_start_sig) begin
      m_step <= 8'h00;
      m_done <= 1'b0;
    end else begin
      if (m_step != 8'hFF) m_step <= m_step + 8'h01;
      m_done <= !stuck && (m_step == 8'd9);
    end
  end

  function automatic logic [15:0] model_div(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] am, bm, q, r;
    am = a[7] ? 8'(-a) : a;
    bm = b[7] ? 8'(-b) : b;
    if (bm == 8'h00) return {8'hFF, a};
    q = am / bm;
    r = am % bm;
    if (a[7] ^ b[7]) q = 8'(-q);
    return {q, r};
  endfunction

  logic [15:0] m_res;
  assign m_res        = model_div(div_dividend, div_divisor);
  assign div_done_sig = m_done;
  assign div_quotient = m_res[15:8];
  assign div_reminder = m_res[7:0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and activity monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      cyc++;
      if (div_start_sig) start_cycles++;
      if (div_done_sig) done_pulses++;
      if (out_valid && out_ready) begin
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          check("result", {14'd0, out_dz, out_timeout, out_quotient, out_reminder},
                {14'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    stuck = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    in_dividend = a;
    in_divisor = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("wait_valid_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((busy || out_valid) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) check("drain_timeout", 32'd1, 32'd0);
  endtask

  logic [7:0] ta [6] = '{8'd50, 8'hCE, 8'd127, 8'h80, 8'd7, 8'd1};
  logic [7:0] tb [6] = '{8'd5, 8'd6, 8'hFF, 8'd3, 8'd9, 8'd1};
  logic [15:0] tr [5] = '{16'h0A00, 16'hF802, 16'h8100, 16'hD602, 16'h0007};

  initial begin
    int n;
    int acc;

    // Reset state
    repeat (2) tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_start", div_start_sig, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_outs", {out_quotient, out_reminder, out_dz, out_timeout}, 18'd0);
    check("rst_state", fsm_state, 2'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", in_ready, 1'b1);

    // 100 / 7
    out_ready = 1'b1;
    start_cycles = 0;
    done_pulses = 0;
    exp_q.push_back({2'b00, 8'h0E, 8'h02});
    push(8'h64, 8'h07);
    wait_valid(n);
    check("lat_100_7", n, 12);
    repeat (20) tick();
    check("start_cycles_100_7", start_cycles, 11);
    check("done_pulses_100_7", done_pulses, 1);
    check("div_step_idle", m_step, 8'd0);

    // -100/7 then 100/-7 back to back
    hs_cyc.delete();
    exp_q.push_back({2'b00, 8'hF2, 8'h02});
    exp_q.push_back({2'b00, 8'hF2, 8'h02});
    push(8'h9C, 8'h07);
    push(8'h64, 8'hF9);
    wait_drain();
    check("b2b_count", hs_cyc.size(), 2);
    if (hs_cyc.size() == 2) check("b2b_spacing", hs_cyc[1] - hs_cyc[0], 13);

    // Divide by zero
    start_cycles = 0;
    exp_q.push_back({2'b10, 8'hFF, 8'h2A});
    push(8'h2A, 8'h00);
    wait_valid(n);
    check("lat_dz", n, 1);
    wait_drain();
    check("dz_start_cycles", start_cycles, 0);

    // Back-pressure: six continuous pushes with out_ready low
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_dividend = ta[i];
      in_divisor = tb[i];
      check($sformatf("bp_in_ready_%0d", i), in_ready, (i < 5) ? 1'b1 : 1'b0);
      if (in_ready) begin
        acc++;
        exp_q.push_back({2'b00, tr[i]});
      end
      tick();
    end
    in_valid = 1'b0;
    check("bp_accepted", acc, 5);
    wait_valid(n);
    check("bp_state_resp", fsm_state, 2'd2);
    check("bp_full", in_ready, 1'b0);
    out_ready = 1'b1;
    tick();
    check("bp_ready_after_hs", in_ready, 1'b0);
    tick();
    check("bp_ready_after_pop", in_ready, 1'b1);
    wait_drain();
    check("bp_drained", exp_q.size(), 0);

    // Timeout with a stuck divider
    stuck = 1'b1;
    start_cycles = 0;
    exp_q.push_back({2'b01, 8'h00, 8'h00});
    push(8'd9, 8'd3);
    wait_valid(n);
    check("to_latency", n, 33);
    check("to_start_cycles", start_cycles, 32);
    check("to_start_low", div_start_sig, 1'b0);
    tick();
    do_reset();

    // Reset in the middle of a RUN with two entries queued
    push(8'd20, 8'd3);
    push(8'd21, 8'd3);
    push(8'd22, 8'd3);
    repeat (3) tick();
    check("mid_run_state", fsm_state, 2'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_start", div_start_sig, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_outs", {out_valid, out_quotient, out_reminder, out_dz, out_timeout}, 19'd0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();
    exp_q.push_back({2'b00, 8'h0E, 8'h02});
    push(8'h64, 8'h07);
    wait_valid(n);
    check("post_rst_lat", n, 12);
    wait_drain();
    check("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
